// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired control unit for instruction fetch and
// ALU-class execution. A Moore FSM steps through T0..T6, decoding the
// opcode held in IR at T3, and drives the datapath strobes, one-hot
// register selects and one-hot ALU operation selects.
//
// Optional build macro CTRL_INSTR_COUNT_EN adds a 32-bit retired
// instruction counter output (instr_count).
module alu_control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic [31:0]         IR,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MDRout,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                HIout,
    output logic                LOout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [12:0]         alu_sel,
    output logic                halted,
    output logic                illegal
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [31:0]         instr_count
`endif
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_T0     = 4'd1;
    localparam logic [3:0] S_T1     = 4'd2;
    localparam logic [3:0] S_T2     = 4'd3;
    localparam logic [3:0] S_T3     = 4'd4;
    localparam logic [3:0] S_T4     = 4'd5;
    localparam logic [3:0] S_T5     = 4'd6;
    localparam logic [3:0] S_T6     = 4'd7;
    localparam logic [3:0] S_HALTED = 4'd8;

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic             t1_first;
    logic [OPC_W-1:0] opcode;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic [3:0]       rc;
    logic             is_two;
    logic             is_md;
    logic             is_un;
    logic             is_halt;
    logic             is_undef;
    logic             final_exec;
    logic [3:0]       end_state;
    logic [12:0]      alu_onehot;
    logic             unused_ir;

    // One-hot register select from a 4-bit register field.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
        reg_sel = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign opcode     = IR[31:32-OPC_W];
    assign ra         = IR[26:23];
    assign rb         = IR[22:19];
    assign rc         = IR[18:15];
    assign unused_ir  = ^IR[14:0];

    assign is_two     = (opcode <= OPC_W'(8));
    assign is_md      = (opcode == OPC_W'(9)) || (opcode == OPC_W'(10));
    assign is_un      = (opcode == OPC_W'(11)) || (opcode == OPC_W'(12));
    assign is_halt    = (opcode == OPC_W'(31));
    assign is_undef   = !(is_two || is_md || is_un || is_halt);
    assign alu_onehot = 13'd1 << opcode;

    // The cycle in which an instruction retires: its last execute state.
    assign final_exec = ((state == S_T5) && is_two) ||
                        ((state == S_T6) && is_md)  ||
                        ((state == S_T4) && is_un);
    assign end_state  = Run ? S_T0 : S_IDLE;

    // State register, first-T1 marker and sticky illegal-opcode flag.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state    <= S_IDLE;
            t1_first <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nxt;
            t1_first <= (state == S_T0);
            if ((state == S_T3) && is_undef)
                illegal <= 1'b1;
        end
    end

`ifdef CTRL_INSTR_COUNT_EN
    // Retired ALU/MUL/DIV instruction counter; wraps naturally at 2^32.
    always_ff @(posedge Clock) begin
        if (Clear)
            instr_count <= '0;
        else if (final_exec)
            instr_count <= instr_count + 32'd1;
    end
`endif

    // Next-state decode; the opcode only steers the sequence from T3 on.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = Run ? S_T0 : S_IDLE;
            S_T0:     state_nxt = S_T1;
            S_T1:     state_nxt = mem_ready ? S_T2 : S_T1;
            S_T2:     state_nxt = S_T3;
            S_T3: begin
                if (is_two || is_md || is_un)
                    state_nxt = S_T4;
                else if (is_halt)
                    state_nxt = S_HALTED;
                else
                    state_nxt = end_state;
            end
            S_T4:     state_nxt = is_un ? end_state : S_T5;
            S_T5:     state_nxt = is_md ? S_T6 : end_state;
            S_T6:     state_nxt = end_state;
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode from registered state plus IR fields only.
    always_comb begin
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Rout     = '0;
        Rin      = '0;
        alu_sel  = '0;
        halted   = 1'b0;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                // Only the first T1 cycle writes the incremented PC back.
                Zlowout = t1_first;
                PCin    = t1_first;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_two || is_md) begin
                    Rout = reg_sel(rb);
                    Yin  = 1'b1;
                end else if (is_un) begin
                    Rout    = reg_sel(rb);
                    alu_sel = alu_onehot;
                    Zin     = 1'b1;
                end
            end
            S_T4: begin
                if (is_two || is_md) begin
                    Rout    = reg_sel(rc);
                    alu_sel = alu_onehot;
                    Zin     = 1'b1;
                end else if (is_un) begin
                    Zlowout = 1'b1;
                    Rin     = reg_sel(ra);
                end
            end
            S_T5: begin
                if (is_two) begin
                    Zlowout = 1'b1;
                    Rin     = reg_sel(ra);
                end else if (is_md) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin
                if (is_md) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench for alu_control_sequencer: the stimulus process pushes
// the expected output vector for every clock cycle into a queue; a monitor
// pops and compares on each falling edge.
module tb_alu_control_sequencer;

    localparam logic [15:0] PCOUT  = 16'h8000;
    localparam logic [15:0] MDROUT = 16'h4000;
    localparam logic [15:0] ZHOUT  = 16'h2000;
    localparam logic [15:0] ZLOUT  = 16'h1000;
    localparam logic [15:0] PCIN   = 16'h0200;
    localparam logic [15:0] MARIN  = 16'h0100;
    localparam logic [15:0] MDRIN  = 16'h0080;
    localparam logic [15:0] IRIN   = 16'h0040;
    localparam logic [15:0] YIN    = 16'h0020;
    localparam logic [15:0] ZIN    = 16'h0010;
    localparam logic [15:0] HIIN   = 16'h0008;
    localparam logic [15:0] LOIN   = 16'h0004;
    localparam logic [15:0] INCPC  = 16'h0002;
    localparam logic [15:0] READ   = 16'h0001;

    localparam logic [31:0] IR_ROR  = 32'h28918000;
    localparam logic [31:0] IR_MUL  = 32'h48228000;
    localparam logic [31:0] IR_ADD  = 32'h00918000;
    localparam logic [31:0] IR_NEG  = 32'h5BB00000;
    localparam logic [31:0] IR_NOT  = 32'h60780000;
    localparam logic [31:0] IR_BAD  = 32'hA0000000;
    localparam logic [31:0] IR_HALT = 32'hF8000000;

    typedef struct {
        string       nm;
        logic [62:0] v;
        logic [31:0] cnt;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Run = 1'b0;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read;
    logic [15:0] Rout, Rin;
    logic [12:0] alu_sel;
    logic        halted, illegal;
    logic [31:0] cnt_obs;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        exp_ill = 1'b0;
    logic [31:0] exp_cnt = '0;

    alu_control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin), .alu_sel(alu_sel),
        .halted(halted), .illegal(illegal)
`ifdef CTRL_INSTR_COUNT_EN
        , .instr_count(cnt_obs)
`endif
    );

`ifndef CTRL_INSTR_COUNT_EN
    assign cnt_obs = '0;
`endif

    always #5 Clock = ~Clock;

    // Advance one clock and record what the DUT must show in the new cycle.
    task automatic tick(input string nm, input logic [15:0] ctrl,
                        input logic [15:0] rout, input logic [15:0] rin,
                        input logic [12:0] alu, input logic h);
        exp_t e;
        @(posedge Clock);
        #1;
        e.nm  = nm;
        e.v   = {ctrl, rout, rin, alu, h, exp_ill};
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic t0(input string nm);
        tick(nm, PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 13'h0, 1'b0);
    endtask

    // T1 (plus wait cycles) and T2; the caller has already entered T0.
    task automatic fetch(input string nm, input int waits);
        mem_ready = 1'b0;
        tick({nm, "_T1"}, ZLOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 13'h0, 1'b0);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            tick({nm, "_T1wait"}, READ | MDRIN, 16'h0, 16'h0, 13'h0, 1'b0);
        end
        mem_ready = 1'b1;
        tick({nm, "_T2"}, MDROUT | IRIN, 16'h0, 16'h0, 13'h0, 1'b0);
    endtask

    // Monitor: compare every cycle the scoreboard holds an expectation for.
    initial begin
        exp_t        e;
        logic [62:0] obs;
        forever begin
            @(negedge Clock);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                obs = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
                       PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read,
                       Rout, Rin, alu_sel, halted, illegal};
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL %s: outputs got %h expected %h", e.nm, obs, e.v);
                end
`ifdef CTRL_INSTR_COUNT_EN
                checks++;
                if (cnt_obs !== e.cnt) begin
                    errors++;
                    $display("FAIL %s_count: got %0d expected %0d", e.nm, cnt_obs, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        Clear = 1'b1; Run = 1'b0;
        tick("reset", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);
        Clear = 1'b0;
        tick("idle", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);
        Run = 1'b1;
        t0("start_T0");

        // ROR R1,R2,R3
        IR = IR_ROR;
        fetch("ror", 0);
        tick("ror_T3", YIN, 16'h0004, 16'h0, 13'h0, 1'b0);
        tick("ror_T4", ZIN, 16'h0008, 16'h0, 13'h0020, 1'b0);
        tick("ror_T5", ZLOUT, 16'h0, 16'h0002, 13'h0, 1'b0);
        exp_cnt = 32'd1;
        t0("ror_next_T0");

        // MUL R4,R5
        IR = IR_MUL;
        fetch("mul", 0);
        tick("mul_T3", YIN, 16'h0010, 16'h0, 13'h0, 1'b0);
        tick("mul_T4", ZIN, 16'h0020, 16'h0, 13'h0200, 1'b0);
        tick("mul_T5", ZLOUT | LOIN, 16'h0, 16'h0, 13'h0, 1'b0);
        tick("mul_T6", ZHOUT | HIIN, 16'h0, 16'h0, 13'h0, 1'b0);
        exp_cnt = 32'd2;
        t0("mul_next_T0");

        // ADD R1,R2,R3 with three memory wait cycles
        IR = IR_ADD;
        fetch("add_wait", 3);
        tick("add_wait_T3", YIN, 16'h0004, 16'h0, 13'h0, 1'b0);
        tick("add_wait_T4", ZIN, 16'h0008, 16'h0, 13'h0001, 1'b0);
        tick("add_wait_T5", ZLOUT, 16'h0, 16'h0002, 13'h0, 1'b0);
        exp_cnt = 32'd3;
        t0("add_wait_next_T0");

        // NEG R7,R6
        IR = IR_NEG;
        fetch("neg", 0);
        tick("neg_T3", ZIN, 16'h0040, 16'h0, 13'h0800, 1'b0);
        tick("neg_T4", ZLOUT, 16'h0, 16'h0080, 13'h0, 1'b0);
        exp_cnt = 32'd4;
        t0("neg_next_T0");

        // NOT R0,R15: Ra=0 is an ordinary destination
        IR = IR_NOT;
        fetch("not", 0);
        tick("not_T3", ZIN, 16'h8000, 16'h0, 13'h1000, 1'b0);
        tick("not_T4", ZLOUT, 16'h0, 16'h0001, 13'h0, 1'b0);
        exp_cnt = 32'd5;
        t0("not_next_T0");

        // Undefined opcode 20: NOP with sticky illegal, not counted
        IR = IR_BAD;
        fetch("bad", 0);
        tick("bad_T3", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);
        exp_ill = 1'b1;
        t0("bad_next_T0");

        // Clear during T4 of ADD abandons it
        IR = IR_ADD;
        fetch("add_clr", 0);
        tick("add_clr_T3", YIN, 16'h0004, 16'h0, 13'h0, 1'b0);
        tick("add_clr_T4", ZIN, 16'h0008, 16'h0, 13'h0001, 1'b0);
        Clear = 1'b1;
        exp_ill = 1'b0;
        exp_cnt = 32'd0;
        tick("clear_mid", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);
        Clear = 1'b0;
        t0("restart_T0");

        // Two complete ADDs; Run drops at the end of the second
        fetch("add1", 0);
        tick("add1_T3", YIN, 16'h0004, 16'h0, 13'h0, 1'b0);
        tick("add1_T4", ZIN, 16'h0008, 16'h0, 13'h0001, 1'b0);
        tick("add1_T5", ZLOUT, 16'h0, 16'h0002, 13'h0, 1'b0);
        exp_cnt = 32'd1;
        t0("add1_next_T0");
        fetch("add2", 0);
        tick("add2_T3", YIN, 16'h0004, 16'h0, 13'h0, 1'b0);
        tick("add2_T4", ZIN, 16'h0008, 16'h0, 13'h0001, 1'b0);
        tick("add2_T5", ZLOUT, 16'h0, 16'h0002, 13'h0, 1'b0);
        Run = 1'b0;
        exp_cnt = 32'd2;
        tick("add2_to_idle", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);
        tick("idle_hold", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);

        // HALT: stays halted until Clear
        Run = 1'b1;
        t0("halt_T0");
        IR = IR_HALT;
        fetch("halt", 0);
        tick("halt_T3", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);
        tick("halted1", 16'h0, 16'h0, 16'h0, 13'h0, 1'b1);
        tick("halted2", 16'h0, 16'h0, 16'h0, 13'h0, 1'b1);
        Run = 1'b0;
        tick("halted3", 16'h0, 16'h0, 16'h0, 13'h0, 1'b1);
        Clear = 1'b1;
        exp_cnt = 32'd0;
        tick("halt_clear", 16'h0, 16'h0, 16'h0, 13'h0, 1'b0);
        Clear = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge Clock);
        @(posedge Clock);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hardwired control unit that generates, cycle by cycle, the datapath control strobes for instruction fetch and ALU-class execution.
- Drives the DataPath control inputs: PC/MAR/MDR/IR/Y/Z/HI/LO strobes, one-hot register in/out selects and one-hot ALU operation selects.
- Sits between the instruction register and the datapath. It replaces hand-sequenced control with an FSM that decodes IR and steps through T0..T6.

Parameters:
- NUM_REGS, 16, number of general registers; width of the one-hot select buses.
- OPC_W, 5, opcode width, taken from IR[31:32-OPC_W].

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Clear  in  1  synchronous, active-high reset.
- Run  in  1  start/continue enable, sampled in IDLE.
- IR  in  32  instruction register contents. Fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- mem_ready  in  1  memory read data valid on Mdatain.
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout  out  1 each  bus drive strobes.
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load strobes.
- IncPC, Read  out  1 each  PC increment select; memory read.
- Rout  out  NUM_REGS  one-hot register bus drive (bit n = Rnout).
- Rin  out  NUM_REGS  one-hot register load (bit n = Rnin).
- alu_sel  out  13  one-hot ALU op. Bit order [0..12]: ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT.
- halted  out  1  high in HALTED state.
- illegal  out  1  sticky flag: an undefined opcode was decoded.

Behaviour:
- Moore FSM. Every output is a pure decode of the registered state plus IR fields, with no glitching between states.
- At most one Rout bit and one Rin bit are high in any state. At most one bus-drive strobe is high in any state.
- Clear=1 at any rising edge, including mid-instruction:
  - state goes to IDLE; illegal goes to 0.
  - All outputs are 0 in the following cycle. An in-flight instruction is abandoned with no register write.
- IDLE: all outputs 0. Run=1 → T0; else stay in IDLE.
- T0: PCout, MARin, IncPC, Zin → T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while mem_ready=0. Only the first T1 cycle asserts PCin; later wait cycles assert Read and MDRin only.
  - mem_ready=1 → T2.
- T2: MDRout, IRin → T3. IR is valid from T3 onward.
- Decode at T3 on the opcode. Opcode codes: 0 ADD, 1 SUB, 2 SHR, 3 SHRA, 4 SHL, 5 ROR, 6 ROL, 7 AND, 8 OR, 9 MUL, 10 DIV, 11 NEG, 12 NOT, 31 HALT.
- Two-operand ops (0..8):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_sel[op], Zin.
  - T5: Zlowout, Rin[Ra] → T0 if Run=1, else IDLE.
- MUL/DIV (9, 10):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_sel[op], Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin → T0/IDLE per Run.
  - Ra is ignored.
- Unary ops (11, 12):
  - T3: Rout[Rb], alu_sel[op], Zin.
  - T4: Zlowout, Rin[Ra] → T0/IDLE per Run.
- HALT (31): at T3, go to HALTED. HALTED stays there, all outputs 0 and halted=1, until Clear.
- Undefined opcode (13..30): at T3, set illegal=1 with all outputs 0. Next state is T0/IDLE per Run; the instruction is treated as a NOP.
- Ra = 0 is a valid destination; there is no R0 special-casing.
- Instruction lengths with mem_ready=1 in T1:
  - two-operand: 6 cycles (T0..T5).
  - MUL/DIV: 7 cycles.
  - unary: 5 cycles.
  - Each wait cycle in T1 adds 1.

Optional Feature:
- Macro: CTRL_INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count, 32 bits, reset to 0 by Clear.
  - Increments by 1 on the final execute state of each retired ALU/MUL/DIV instruction. HALT and illegal opcodes are not counted.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- ROR R1,R2,R3 (IR=0x28918000, Run=1, mem_ready=1) → T3: Rout=0x0004 with Yin. T4: Rout=0x0008, alu_sel=0x0020, Zin. T5: Zlowout with Rin=0x0002. Back in T0 six cycles after the first T0.
- MUL R4,R5 (IR=0x48228000) → T5: Zlowout+LOin. T6: Zhighout+HIin. Rin stays 0x0000 throughout.
- mem_ready held low 3 cycles in T1 → exactly 4 T1 cycles; PCin high only in the first; Read and MDRin high in all 4.
- NEG R7,R6 (IR=0x5BB00000) → T3: Rout=0x0040, alu_sel=0x0800, Zin. T4: Rin=0x0080. Five cycles total.
- Opcode 20 (IR=0xA0000000) → illegal=1 after T3, no Rin asserted, next state T0. HALT (IR=0xF8000000) → halted=1 and stays high.
- Clear asserted during T4 of ADD → next cycle IDLE with all outputs 0. With CTRL_INSTR_COUNT_EN, instr_count=0, and it counts 2 after two completed ADDs.
